// File: rtl/change_dispenser.sv
// Greedy four-denomination change payout with inventory tracking,
// one-hot coin eject handshake and jam timeout.
module change_dispenser #(
  parameter int AMT_W = 8,
  parameter int INV_W = 8,
  parameter int DEN3 = 20,
  parameter int DEN2 = 10,
  parameter int DEN1 = 5,
  parameter int DEN0 = 1,
  parameter logic [INV_W-1:0] INIT_INV = INV_W'(10),
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               change_dispense_en,
  input  logic [AMT_W-1:0]   change_amount,
  input  logic               refill,
  input  logic [4*INV_W-1:0] refill_cnt,
  input  logic               coin_sensed,
  output logic [3:0]         coin_eject,
  output logic               change_dispense_done,
  output logic               change_error,
  output logic [1:0]         err_code,
  output logic [AMT_W-1:0]   remaining,
  output logic               busy,
  output logic [4*INV_W-1:0] inv_cnt
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [3:0][AMT_W-1:0] DEN_TAB = {
    AMT_W'(DEN3), AMT_W'(DEN2), AMT_W'(DEN1), AMT_W'(DEN0)
  };

  typedef enum logic [2:0] {
    IDLE, SELECT, EJECT, DONE, ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [AMT_W-1:0]         rem_q, rem_d;
  logic [3:0][INV_W-1:0]    inv_q, inv_d;
  logic [1:0]               sel_q, sel_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               err_q, err_d;
  logic                     en_q, en_d;
  logic                     start;

  assign start = change_dispense_en & ~en_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    inv_d   = inv_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    en_d    = change_dispense_en;
    unique case (state_q)
      IDLE: begin
        if (refill) inv_d = refill_cnt;
        if (start) begin
          rem_d   = change_amount;
          err_d   = 2'b00;
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d = '0;
        // Largest coin that fits and is in stock wins
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (rem_q >= DEN_TAB[3] && inv_q[3] != '0) begin
          sel_d   = 2'd3;
          state_d = EJECT;
        end else if (rem_q >= DEN_TAB[2] && inv_q[2] != '0) begin
          sel_d   = 2'd2;
          state_d = EJECT;
        end else if (rem_q >= DEN_TAB[1] && inv_q[1] != '0) begin
          sel_d   = 2'd1;
          state_d = EJECT;
        end else if (rem_q >= DEN_TAB[0] && inv_q[0] != '0) begin
          sel_d   = 2'd0;
          state_d = EJECT;
        end else begin
          err_d   = 2'b01;
          state_d = ERROR;
        end
      end
      EJECT: begin
        if (coin_sensed) begin
          inv_d[sel_q] = inv_q[sel_q] - 1'b1;
          rem_d        = rem_q - DEN_TAB[sel_q];
          cnt_d        = '0;
          state_d      = SELECT;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 2'b10;
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:  state_d = IDLE;
      ERROR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      inv_q   <= {4{INIT_INV}};
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 2'b00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      inv_q   <= inv_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      en_q    <= en_d;
    end
  end

  assign coin_eject = (state_q == EJECT) ? (4'b0001 << sel_q) : 4'b0000;
  assign change_dispense_done = (state_q == DONE) || (state_q == ERROR);
  assign change_error = (state_q == ERROR);
  assign err_code  = err_q;
  assign remaining = rem_q;
  assign busy      = (state_q != IDLE);
  assign inv_cnt   = inv_q;

endmodule
